// File: rtl/puf_pkg.sv
// ----------------------------------------------------------------------------
// puf_pkg
// Shared types and constants for the arbiter-PUF response controller.
//   state_t        : controller FSM states
//   ZERO_SEED_SUB  : challenge loaded in place of an all-zero seed
//   lfsr_taps()    : feedback tap mask for a given switch-chain length
// ----------------------------------------------------------------------------
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   // All-zero is the LFSR lock-up state, so a zero seed is replaced by this.
   localparam int ZERO_SEED_SUB = 1;

   // Tap mask is returned at the widest supported length; callers keep the
   // low STAGES bits.
   function automatic logic [127:0] lfsr_taps(input int stages);
      logic [127:0] m;
      m = '0;
      case (stages)
         32: begin
            m[31] = 1'b1; m[21] = 1'b1; m[1]  = 1'b1; m[0]  = 1'b1;
         end
         64: begin
            m[63] = 1'b1; m[62] = 1'b1; m[60] = 1'b1; m[59] = 1'b1;
         end
         default: begin
            m[127] = 1'b1; m[125] = 1'b1; m[100] = 1'b1; m[98] = 1'b1;
         end
      endcase
      return m;
   endfunction

endpackage

// File: rtl/puf_sync2.sv
// ----------------------------------------------------------------------------
// puf_sync2
// Two-flop synchroniser bringing the asynchronous arbiter output into clk.
//   clk : sampling clock
//   rst : synchronous active-high reset (clears both stages)
//   d   : asynchronous input
//   q   : synchronised output, two edges behind d
// ----------------------------------------------------------------------------
module puf_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/puf_response_ctrl.sv
// ----------------------------------------------------------------------------
// puf_response_ctrl
// Drives the challenge bus of an external arbiter-PUF switch chain, pulses
// launch once per evaluation, samples the arbiter after a settle window and
// majority-votes VOTES evaluations into each response bit. The seed is
// expanded by an LFSR into RESP_BITS challenges; the response word is
// returned over a valid/ready handshake.
//   clk, rst               : clock, synchronous active-high reset
//   seed_valid/seed_ready  : seed handshake, seed = first challenge
//   challenge              : registered switch-chain selects
//   launch                 : registered one-cycle pulse per evaluation
//   arb_in                 : asynchronous arbiter output
//   resp_valid/resp_ready  : response handshake, resp[i] = i-th challenge
//   busy                   : controller not idle
// ----------------------------------------------------------------------------
module puf_response_ctrl
   import puf_pkg::*;
#(
   parameter int STAGES        = 64,
   parameter int RESP_BITS     = 32,
   parameter int SETTLE_CYCLES = 8,
   parameter int VOTES         = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 seed_valid,
   output logic                 seed_ready,
   input  logic [STAGES-1:0]    seed,
   output logic [STAGES-1:0]    challenge,
   output logic                 launch,
   input  logic                 arb_in,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [RESP_BITS-1:0] resp,
   output logic                 busy
);

   localparam int BW = $clog2(RESP_BITS + 1);
   localparam logic [127:0]       TAPS_FULL = lfsr_taps(STAGES);
   localparam logic [STAGES-1:0]  TAPS      = TAPS_FULL[STAGES-1:0];

   state_t          state, next_state;
   logic [BW-1:0]   bit_cnt;
   logic [3:0]      vote_cnt;
   logic [3:0]      ones_cnt;
   logic [7:0]      settle_cnt;
   logic            arb_s;
   logic            fb;
   logic            seed_acc;
   logic            settle_last, vote_last, bit_last;
   logic            vote_bit;
   logic            launch_nxt, resp_valid_nxt;

   puf_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (arb_in),
      .q   (arb_s)
   );

   assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
   assign vote_last   = (vote_cnt == 4'(VOTES - 1));
   assign bit_last    = (bit_cnt == BW'(RESP_BITS - 1));
   assign seed_acc    = seed_valid && seed_ready;
   assign fb          = ^(challenge & TAPS);
   // ones_cnt already holds the last vote when NEXT is reached.
   assign vote_bit    = (ones_cnt > 4'(VOTES / 2));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (seed_acc) next_state = LAUNCH;
         LAUNCH:  next_state = SETTLE;
         SETTLE:  if (settle_last) next_state = SAMPLE;
         SAMPLE:  next_state = vote_last ? NEXT : LAUNCH;
         NEXT:    next_state = bit_last ? DONE : LAUNCH;
         DONE:    if (resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // launch and resp_valid are registered from the upcoming state so they
   // line up exactly with LAUNCH / DONE.
   always_comb begin
      seed_ready     = (state == IDLE) && !rst;
      busy           = (state != IDLE);
      launch_nxt     = (next_state == LAUNCH);
      resp_valid_nxt = (next_state == DONE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         challenge  <= '0;
         launch     <= 1'b0;
         resp_valid <= 1'b0;
         resp       <= '0;
         bit_cnt    <= '0;
         vote_cnt   <= '0;
         ones_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         launch     <= launch_nxt;
         resp_valid <= resp_valid_nxt;
         case (state)
            IDLE: begin
               if (seed_acc) begin
                  challenge <= (seed == '0) ? STAGES'(ZERO_SEED_SUB) : seed;
                  bit_cnt   <= '0;
                  vote_cnt  <= '0;
                  ones_cnt  <= '0;
               end
            end
            LAUNCH: settle_cnt <= '0;
            SETTLE: settle_cnt <= settle_cnt + 8'd1;
            SAMPLE: begin
               ones_cnt <= ones_cnt + {3'b000, arb_s};
               vote_cnt <= vote_cnt + 4'd1;
            end
            NEXT: begin
               // Decoded write avoids an index wider than resp needs.
               for (int i = 0; i < RESP_BITS; i++)
                  if (bit_cnt == BW'(i)) resp[i] <= vote_bit;
               challenge <= {challenge[STAGES-2:0], fb};
               vote_cnt  <= '0;
               ones_cnt  <= '0;
               bit_cnt   <= bit_cnt + BW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_response_ctrl.sv
module tb_puf_response_ctrl;

   localparam int STAGES    = 64;
   localparam int RESP_BITS = 32;
   localparam int SETTLE    = 8;
   localparam int VOTES     = 3;
   localparam int TBIT      = VOTES * (SETTLE + 2) + 1;
   localparam int NL        = RESP_BITS * VOTES;
   localparam int EXP_LAT   = 1 + RESP_BITS * TBIT;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 seed_valid = 1'b0;
   logic                 seed_ready;
   logic [STAGES-1:0]    seed = '0;
   logic [STAGES-1:0]    challenge;
   logic                 launch;
   logic                 arb_in = 1'b0;
   logic                 resp_valid;
   logic                 resp_ready = 1'b0;
   logic [RESP_BITS-1:0] resp;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   logic [RESP_BITS-1:0] exp_q[$];
   bit                   pat[NL];
   logic [STAGES-1:0]    chal_log[NL];
   int                   nlaunch;
   int                   done_cyc;
   bit                   timed_out;

   puf_response_ctrl #(
      .STAGES(STAGES), .RESP_BITS(RESP_BITS),
      .SETTLE_CYCLES(SETTLE), .VOTES(VOTES)
   ) dut (
      .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed(seed), .challenge(challenge), .launch(launch), .arb_in(arb_in),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [RESP_BITS-1:0] maj_model();
      logic [RESP_BITS-1:0] r;
      int ones;
      r = '0;
      for (int b = 0; b < RESP_BITS; b++) begin
         ones = 0;
         for (int v = 0; v < VOTES; v++) ones += int'(pat[b*VOTES+v]);
         r[b] = (ones > VOTES / 2);
      end
      return r;
   endfunction

   function automatic logic [STAGES-1:0] lfsr_step(input logic [STAGES-1:0] c);
      logic f;
      f = c[63] ^ c[62] ^ c[60] ^ c[59];
      return {c[62:0], f};
   endfunction

   task automatic fill_pat(input int mode);
      for (int i = 0; i < NL; i++)
         pat[i] = (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode);
   endtask

   task automatic start_seed(input logic [STAGES-1:0] s);
      exp_q.push_back(maj_model());
      @(negedge clk);
      seed_valid = 1'b1;
      seed       = s;
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
   endtask

   // Steps the run after a seed handshake, feeding arb_in per launch.
   task automatic wait_done();
      nlaunch   = 0;
      done_cyc  = -1;
      timed_out = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         if (launch) begin
            if (nlaunch < NL) begin
               chal_log[nlaunch] = challenge;
               arb_in = pat[nlaunch];
            end
            nlaunch++;
         end
         if (resp_valid) begin
            done_cyc = n + 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (done_cyc < 0) timed_out = 1'b1;
   endtask

   task automatic finish_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (seed_ready !== 1'b0) begin
         errors++; $display("FAIL rst_seed_ready_in_rst got %b want 0", seed_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (challenge !== '0 || launch !== 1'b0 || resp_valid !== 1'b0 ||
          resp !== '0 || busy !== 1'b0 || seed_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got chal=%h launch=%b rv=%b resp=%h busy=%b sr=%b want 0/0/0/0/0/1",
                  challenge, launch, resp_valid, resp, busy, seed_ready);
      end
   endtask

   task automatic test_const(input int level);
      logic [RESP_BITS-1:0] e;
      fill_pat(level);
      start_seed(64'h1);
      wait_done();
      checks++;
      if (timed_out) begin errors++; $display("FAIL const%0d_timeout got none want resp_valid", level); end
      checks++;
      if (done_cyc !== EXP_LAT) begin
         errors++; $display("FAIL const%0d_latency got %0d want %0d", level, done_cyc, EXP_LAT);
      end
      checks++;
      if (nlaunch !== NL) begin
         errors++; $display("FAIL const%0d_launches got %0d want %0d", level, nlaunch, NL);
      end
      e = exp_q.pop_front();
      checks++;
      if (resp !== e || resp !== (level == 1 ? 32'hFFFF_FFFF : 32'h0)) begin
         errors++; $display("FAIL const%0d_resp got %h want %h", level, resp, e);
      end
      checks++;
      if (chal_log[0] !== 64'h1 || chal_log[2] !== 64'h1 ||
          chal_log[3] !== 64'h2 || chal_log[6] !== 64'h4) begin
         errors++;
         $display("FAIL lfsr_seed1 got %h %h %h %h want 1 1 2 4",
                  chal_log[0], chal_log[2], chal_log[3], chal_log[6]);
      end
      finish_resp();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || seed_ready !== 1'b1) begin
         errors++; $display("FAIL const%0d_return_idle got rv=%b busy=%b sr=%b want 0 0 1",
                            level, resp_valid, busy, seed_ready);
      end
   endtask

   task automatic test_majority();
      logic [RESP_BITS-1:0] e;
      fill_pat(2);
      pat[0] = 1; pat[1] = 1; pat[2] = 0;
      pat[3] = 1; pat[4] = 0; pat[5] = 0;
      start_seed({$urandom, $urandom});
      wait_done();
      e = exp_q.pop_front();
      checks++;
      if (timed_out || resp !== e) begin
         errors++; $display("FAIL majority_resp got %h want %h (timeout=%b)", resp, e, timed_out);
      end
      checks++;
      if (resp[0] !== 1'b1 || resp[1] !== 1'b0) begin
         errors++; $display("FAIL majority_bits01 got %b%b want 01", resp[1], resp[0]);
      end
      finish_resp();
   endtask

   task automatic test_lfsr(input logic [STAGES-1:0] s);
      logic [RESP_BITS-1:0] e;
      logic [STAGES-1:0] m;
      int bad;
      fill_pat(2);
      start_seed(s);
      wait_done();
      e = exp_q.pop_front();
      checks++;
      if (timed_out || resp !== e) begin
         errors++; $display("FAIL lfsr_resp got %h want %h (timeout=%b)", resp, e, timed_out);
      end
      m = s;
      bad = 0;
      for (int b = 0; b < RESP_BITS; b++) begin
         for (int v = 0; v < VOTES; v++)
            if (chal_log[b*VOTES+v] !== m) bad++;
         m = lfsr_step(m);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL lfsr_sequence seed=%h got %0d bad launches want 0 (bit1 chal=%h)",
                            s, bad, chal_log[VOTES]);
      end
      if (s == 64'h8000_0000_0000_0000) begin
         checks++;
         if (chal_log[VOTES] !== 64'h1) begin
            errors++; $display("FAIL lfsr_msb_wrap got %h want 1", chal_log[VOTES]);
         end
      end
      finish_resp();
   endtask

   task automatic test_zero_seed();
      logic [RESP_BITS-1:0] e;
      fill_pat(2);
      start_seed(64'h0);
      wait_done();
      e = exp_q.pop_front();
      checks++;
      if (chal_log[0] !== 64'h1) begin
         errors++; $display("FAIL zero_seed_sub got %h want 1", chal_log[0]);
      end
      checks++;
      if (timed_out || resp !== e) begin
         errors++; $display("FAIL zero_seed_resp got %h want %h", resp, e);
      end
      finish_resp();
   endtask

   task automatic test_back_to_back();
      logic [RESP_BITS-1:0] e, snap_r;
      logic [STAGES-1:0]    snap_c, s2;
      int bad;
      fill_pat(2);
      start_seed({$urandom, $urandom});
      wait_done();
      e = exp_q.pop_front();
      checks++;
      if (timed_out || resp !== e) begin
         errors++; $display("FAIL bp_resp got %h want %h", resp, e);
      end
      snap_r = resp;
      snap_c = challenge;
      bad = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b1 || resp !== snap_r || challenge !== snap_c ||
             seed_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
      end
      fill_pat(2);
      s2 = {$urandom, $urandom} | 64'h1;
      exp_q.push_back(maj_model());
      @(negedge clk);
      resp_ready = 1'b1;
      seed_valid = 1'b1;
      seed       = s2;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || launch !== 1'b0 || resp_valid !== 1'b0 || seed_ready !== 1'b1) begin
         errors++; $display("FAIL bp_seed_not_taken got busy=%b launch=%b rv=%b sr=%b want 0 0 0 1",
                            busy, launch, resp_valid, seed_ready);
      end
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
      checks++;
      if (launch !== 1'b1 || challenge !== s2 || busy !== 1'b1) begin
         errors++; $display("FAIL bp_seed_taken got launch=%b chal=%h busy=%b want 1 %h 1",
                            launch, challenge, busy, s2);
      end
      wait_done();
      e = exp_q.pop_front();
      checks++;
      if (timed_out || resp !== e) begin
         errors++; $display("FAIL bp_second_resp got %h want %h", resp, e);
      end
      finish_resp();
   endtask

   task automatic test_reset_mid();
      logic [RESP_BITS-1:0] e;
      bit seen;
      fill_pat(1);
      start_seed(64'h1234_5678_9ABC_DEF0);
      repeat (499) begin
         @(posedge clk);
         #1;
      end
      e = exp_q.pop_front();  // aborted run never answers
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || launch !== 1'b0 || challenge !== '0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset got busy=%b launch=%b chal=%h rv=%b want 0 0 0 0 (dropped %h)",
                            busy, launch, challenge, resp_valid, e);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (seed_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_ready got %b want 1", seed_ready);
      end
      seen = 1'b0;
      repeat (1100) begin
         @(posedge clk);
         #1;
         if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL mid_reset_no_resp got activity want none");
      end
   endtask

   initial begin
      test_reset();
      test_const(1);
      test_const(0);
      test_majority();
      test_lfsr(64'h8000_0000_0000_0000);
      test_lfsr({$urandom, $urandom} | 64'hF000_0000_0000_0000);
      test_zero_seed();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/puf_response_ctrl.md
# puf_response_ctrl

Sequential controller for the arbiter-PUF datapath. It accepts a challenge seed, drives the challenge bus of the external mux-based switch chain, and pulses launch once per evaluation. After a settle window it samples the arbiter output and majority-votes repeated evaluations into one response bit. It expands the seed into RESP_BITS challenges with an LFSR and returns the response word over a valid/ready handshake.

## Interface
- STAGES, 64, challenge width = switch-chain stage count; legal values 32, 64, 128
- RESP_BITS, 32, response bits per seed; 1..256
- SETTLE_CYCLES, 8, cycles between launch and sample; 1..255
- VOTES, 3, evaluations per response bit; odd, 1..15

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- seed_valid  in  1  seed offered
- seed_ready  out  1  high only in IDLE and only while rst is low
- seed  in  STAGES  initial challenge
- challenge  out  STAGES  registered, drives switch-chain selects
- launch  out  1  registered, one-cycle pulse per evaluation
- arb_in  in  1  asynchronous arbiter output
- resp_valid  out  1  response word available
- resp_ready  in  1  consumer accepts
- resp  out  RESP_BITS  response word; bit i = i-th challenge
- busy  out  1  high whenever state is not IDLE

## Operation
- Reset: state IDLE. challenge, launch, resp_valid, resp and all counters are 0.
- arb_in passes through a 2-flop synchroniser to arb_s. All sampling uses arb_s.
- IDLE: seed_valid & seed_ready loads challenge <= seed, or STAGES'h1 if seed == 0, to avoid LFSR lock-up. It clears bit_cnt, vote_cnt and ones_cnt, then goes to LAUNCH.
- LAUNCH (1 cycle): launch = 1, then SETTLE.
- SETTLE (SETTLE_CYCLES cycles): launch = 0, settle counter runs, then SAMPLE.
- SAMPLE (1 cycle): ones_cnt += arb_s and vote_cnt++. If vote_cnt == VOTES-1, go to NEXT; otherwise go to LAUNCH.
- NEXT (1 cycle):
  - resp[bit_cnt] <= (ones_cnt_final > VOTES/2), where ones_cnt_final includes this bit's last sample.
  - challenge advances one LFSR step: {challenge[STAGES-2:0], fb}, with fb = XOR of the bits selected by the package tap mask.
  - Taps: 32 → 31,21,1,0; 64 → 63,62,60,59; 128 → 127,125,100,98.
  - Clears vote_cnt and ones_cnt, then bit_cnt++.
  - If bit_cnt == RESP_BITS-1, go to DONE; otherwise go to LAUNCH.
- DONE: resp_valid = 1; resp and challenge are held stable. On resp_ready, go to IDLE and drop resp_valid.
- Simultaneous seed_valid and resp_ready in DONE: the seed is not taken, because seed_ready = 0. It is accepted in IDLE one cycle later at the earliest.
- Reset mid-operation aborts the run with no resp_valid. Outputs reach reset values on the next edge.
- Counter widths:
  - bit_cnt: $clog2(RESP_BITS+1)
  - vote_cnt and ones_cnt: 4 bits
  - settle counter: 8 bits

## Timing
- Seed handshake at edge 0; LAUNCH occupies cycle 1.
- Cycles per bit: Tb = VOTES*(SETTLE_CYCLES+2)+1.
- resp_valid rises in cycle 1 + RESP_BITS*Tb. With defaults: 1 + 32*31 = 993.
- Launch pulses per seed: RESP_BITS*VOTES (96 with defaults).
- Sample value is arb_in as seen 2 edges earlier. arb_in must be stable from launch+1 through the sample cycle.
- challenge changes only at IDLE load and in NEXT, never between LAUNCH and SAMPLE of one bit.
- DONE→IDLE takes 1 cycle after the resp_ready edge.

## Structure
- Package puf_pkg:
  - state enum {IDLE, LAUNCH, SETTLE, SAMPLE, NEXT, DONE}
  - function lfsr_taps(STAGES) returning the tap mask
  - constant ZERO_SEED_SUB = 1
- Sub-module puf_sync2: parametrised-free 2-flop synchroniser for arb_in.
- FSM, counters, LFSR and response register live in puf_response_ctrl.
- The mux switch chain and arbiter stay outside this block.

## Test plan
- Defaults, seed 64'h1, arb_in held 1 → resp_valid rises at cycle 993 with resp = 32'hFFFF_FFFF; exactly 96 launch pulses. Repeat with arb_in held 0 → resp = 0.
- Majority: arb_in per launch 1,1,0 for bit 0, then 1,0,0 for bit 1 → resp[0] = 1, resp[1] = 0.
- LFSR: seed 64'h1 → challenge is 64'h1 during bit 0, 64'h2 during bit 1, 64'h4 during bit 2. Seed 64'h8000_0000_0000_0000 → bit 1 challenge 64'h1.
- Zero seed 64'h0 → challenge = 64'h1 at the first LAUNCH.
- Backpressure: resp_ready low for 20 cycles in DONE → resp_valid, resp and challenge stable, seed_ready = 0, busy = 1. Raise resp_ready together with seed_valid → seed accepted one cycle later.
- Reset asserted at cycle 500 of a run → next cycle busy = 0, launch = 0, challenge = 0, seed_ready = 1 after rst drops; resp_valid never rises.
